// File: rtl/vip_stream_pkg.sv
// -----------------------------------------------------------------------------
// vip_stream_pkg
// Shared definitions for the VIP frame-stream generator:
//   - pattern-select encodings driven on pattern_sel
//   - FSM state type of the generator
//   - flat-field grey level
//   - cnt_width(): counter width needed to hold 0..n-1 (never below 1 bit)
// -----------------------------------------------------------------------------
package vip_stream_pkg;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  localparam logic [7:0] FLAT_LEVEL = 8'h80;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vip_timing_counter.sv
// -----------------------------------------------------------------------------
// vip_timing_counter
// Raster position counters for the frame-stream generator.
//   h : 0..H_TOTAL-1, advances every cycle while run=1
//   v : 0..V_TOTAL-1, advances when h wraps
//   d : 0..CLKEN_DIV-1, pixel-phase divider, runs only inside the active
//       part of a line and restarts at h=0
//   x : 0..IMG_H-1, pixel index, steps once per completed pixel period
// While run=0 every counter is held at 0, so the next run starts a fresh
// frame at (0,0).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             advance counters (generator in RUN)
//   h_cnt/v_cnt     raster position
//   d_cnt/x_cnt     pixel phase and pixel index
//   in_act          h is inside the active part of the line
//   frame_end       final position of the frame (last h of last line)
// -----------------------------------------------------------------------------
module vip_timing_counter
  import vip_stream_pkg::*;
#(
  parameter int IMG_H     = 640,
  parameter int CLKEN_DIV = 2,
  parameter int H_ACT     = IMG_H * CLKEN_DIV,
  parameter int H_TOTAL   = H_ACT + 16,
  parameter int V_TOTAL   = 486,
  parameter int HW        = cnt_width(H_TOTAL),
  parameter int VW        = cnt_width(V_TOTAL),
  parameter int DW        = cnt_width(CLKEN_DIV),
  parameter int XW        = cnt_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic [DW-1:0] d_cnt,
  output logic [XW-1:0] x_cnt,
  output logic          in_act,
  output logic          frame_end
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_W = HW'(H_ACT);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(CLKEN_DIV - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_H - 1);

  logic [HW-1:0] h_reg;
  logic [VW-1:0] v_reg;
  logic [DW-1:0] d_reg;
  logic [XW-1:0] x_reg;
  logic          line_end;

  assign line_end  = (h_reg == H_LAST);
  assign frame_end = line_end && (v_reg == V_LAST);
  assign in_act    = (h_reg < H_ACT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg <= '0;
      v_reg <= '0;
      d_reg <= '0;
      x_reg <= '0;
    end else if (!run) begin
      h_reg <= '0;
      v_reg <= '0;
      d_reg <= '0;
      x_reg <= '0;
    end else if (line_end) begin
      h_reg <= '0;
      d_reg <= '0;
      x_reg <= '0;
      v_reg <= frame_end ? '0 : v_reg + VW'(1);
    end else begin
      h_reg <= h_reg + HW'(1);
      if (in_act) begin
        // H_ACT is a whole number of pixel periods, so d returns to 0
        // exactly as the active region ends.
        d_reg <= (d_reg == D_LAST) ? '0 : d_reg + DW'(1);
        // x keeps the index of the pixel strobed at d=0 for the whole period
        if (d_reg == D_LAST) begin
          x_reg <= (x_reg == X_LAST) ? '0 : x_reg + XW'(1);
        end
      end
    end
  end

  assign h_cnt = h_reg;
  assign v_cnt = v_reg;
  assign d_cnt = d_reg;
  assign x_cnt = x_reg;

endmodule

// File: rtl/vip_frame_stream_gen.sv
// -----------------------------------------------------------------------------
// vip_frame_stream_gen
// Test-pattern frame source producing the VIP pixel-stream protocol
// (vsync / href / clken / 8-bit Y) for the filter chain during bring-up.
// Frame layout: VS_LINES vsync lines, V_BLANK blank lines, IMG_V active
// lines; every line is IMG_H*CLKEN_DIV active cycles plus H_BLANK blank.
// All outputs are registered from the counter state and lag it by 1 cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            run request (a started frame always completes)
//   pattern_sel       0 h-ramp, 1 v-ramp, 2 checker, 3 flat 0x80;
//                     sampled at the first position of each frame
//   per_frame_vsync   frame sync
//   per_frame_href    active-line window
//   per_frame_clken   pixel strobe
//   per_img_Y         pixel value, updated on clken, held otherwise
//   frame_done        pulse on the last cycle of each frame
//   busy              generator running
//   frame_cnt         (VIP_FRAME_GEN_SCROLL_EN only) completed-frame count
// Build option: define VIP_FRAME_GEN_SCROLL_EN to add frame_cnt and scroll
// the ramp patterns by frame_cnt[7:0] each frame.
// -----------------------------------------------------------------------------
module vip_frame_stream_gen
  import vip_stream_pkg::*;
#(
  parameter int IMG_H     = 640,
  parameter int IMG_V     = 480,
  parameter int H_BLANK   = 16,
  parameter int VS_LINES  = 2,
  parameter int V_BLANK   = 4,
  parameter int CLKEN_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        per_frame_vsync,
  output logic        per_frame_href,
  output logic        per_frame_clken,
  output logic [7:0]  per_img_Y,
  output logic        frame_done,
  output logic        busy
`ifdef VIP_FRAME_GEN_SCROLL_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_ACT   = IMG_H * CLKEN_DIV;
  localparam int H_TOTAL = H_ACT + H_BLANK;
  localparam int V_ACT0  = VS_LINES + V_BLANK;
  localparam int V_TOTAL = V_ACT0 + IMG_V;

  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);
  localparam int DW = cnt_width(CLKEN_DIV);
  localparam int XW = cnt_width(IMG_H);

  localparam logic [VW-1:0] VS_END = VW'(VS_LINES);
  localparam logic [VW-1:0] V_ACT0_W = VW'(V_ACT0);

  gen_state_t    state_reg;
  logic [1:0]    pat_reg;
  logic          vsync_reg;
  logic          href_reg;
  logic          clken_reg;
  logic [7:0]    pix_reg;
  logic          frame_done_reg;
  logic          busy_reg;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [DW-1:0] d_cnt;
  logic [XW-1:0] x_cnt;
  logic          in_act;
  logic          frame_end;

  vip_timing_counter #(
    .IMG_H     (IMG_H),
    .CLKEN_DIV (CLKEN_DIV),
    .H_ACT     (H_ACT),
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL),
    .HW        (HW),
    .VW        (VW),
    .DW        (DW),
    .XW        (XW)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (state_reg == ST_RUN),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .d_cnt     (d_cnt),
    .x_cnt     (x_cnt),
    .in_act    (in_act),
    .frame_end (frame_end)
  );

  // ---------------------------------------------------------------------------
  // Timing decode and pixel value from the current counter state
  // ---------------------------------------------------------------------------
  logic          vsync_c;
  logic          href_c;
  logic          clken_c;
  logic          frame_start;
  logic [VW-1:0] y_cnt;
  logic [7:0]    x8;
  logic [7:0]    y8;
  logic [7:0]    scroll_off;
  logic [7:0]    pix_c;

  assign vsync_c     = (v_cnt < VS_END);
  assign href_c      = (v_cnt >= V_ACT0_W) && in_act;
  assign clken_c     = href_c && (d_cnt == '0);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  // Only meaningful inside href, where v >= V_ACT0 so no underflow occurs.
  assign y_cnt = v_cnt - V_ACT0_W;
  assign x8    = 8'(x_cnt);
  assign y8    = 8'(y_cnt);

`ifdef VIP_FRAME_GEN_SCROLL_EN
  logic [15:0] frame_cnt_reg;
  assign scroll_off = frame_cnt_reg[7:0];
  assign frame_cnt  = frame_cnt_reg;
`else
  assign scroll_off = 8'h00;
`endif

  always_comb begin
    pix_c = FLAT_LEVEL;
    case (pat_reg)
      PAT_HRAMP: pix_c = x8 + scroll_off;
      PAT_VRAMP: pix_c = y8 + scroll_off;
      PAT_CHECK: pix_c = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
      default:   pix_c = FLAT_LEVEL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pat_reg        <= PAT_HRAMP;
      vsync_reg      <= 1'b0;
      href_reg       <= 1'b0;
      clken_reg      <= 1'b0;
      pix_reg        <= 8'h00;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef VIP_FRAME_GEN_SCROLL_EN
      frame_cnt_reg  <= 16'h0000;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Counters sit at (0,0) here, which would decode as vsync, so the
          // outputs are forced low instead of decoded.
          vsync_reg      <= 1'b0;
          href_reg       <= 1'b0;
          clken_reg      <= 1'b0;
          pix_reg        <= 8'h00;
          frame_done_reg <= 1'b0;
          busy_reg       <= 1'b0;
          if (enable) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          vsync_reg      <= vsync_c;
          href_reg       <= href_c;
          clken_reg      <= clken_c;
          frame_done_reg <= frame_end;
          busy_reg       <= 1'b1;
          if (clken_c) begin
            pix_reg <= pix_c;
          end
          // The first active line is never at v=0, so the pattern latched
          // here is in place before any pixel of this frame is produced.
          if (frame_start) begin
            pat_reg <= pattern_sel;
          end
          if (frame_end) begin
`ifdef VIP_FRAME_GEN_SCROLL_EN
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
`endif
            if (!enable) begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign per_frame_vsync = vsync_reg;
  assign per_frame_href  = href_reg;
  assign per_frame_clken = clken_reg;
  assign per_img_Y       = pix_reg;
  assign frame_done      = frame_done_reg;
  assign busy            = busy_reg;

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_vip_frame_stream_gen
// Directed bench for vip_frame_stream_gen. Three instances share clk/rst:
//   dut_a : IMG_H=4,  CLKEN_DIV=1 (H_TOTAL=6,  V_TOTAL=5, 30-cycle frame)
//   dut_b : IMG_H=4,  CLKEN_DIV=2 (H_TOTAL=10, V_TOTAL=5, 50-cycle frame)
//   dut_c : IMG_H=16, CLKEN_DIV=1 (H_TOTAL=18, V_TOTAL=5, 90-cycle frame)
// All use IMG_V=3, H_BLANK=2, VS_LINES=1, V_BLANK=1.
// -----------------------------------------------------------------------------
module tb_vip_frame_stream_gen;
  import vip_stream_pkg::*;

`ifdef VIP_FRAME_GEN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic       clk;
  logic       rst;
  logic       en_a, en_b, en_c;
  logic [1:0] pat_a, pat_b, pat_c;
  logic       vs_a, hr_a, ce_a, fd_a, busy_a;
  logic       vs_b, hr_b, ce_b, fd_b, busy_b;
  logic       vs_c, hr_c, ce_c, fd_c, busy_c;
  logic [7:0] y_a, y_b, y_c;
`ifdef VIP_FRAME_GEN_SCROLL_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  vip_frame_stream_gen #(
    .IMG_H(4), .IMG_V(3), .H_BLANK(2), .VS_LINES(1), .V_BLANK(1), .CLKEN_DIV(1)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .pattern_sel(pat_a),
    .per_frame_vsync(vs_a), .per_frame_href(hr_a), .per_frame_clken(ce_a),
    .per_img_Y(y_a), .frame_done(fd_a), .busy(busy_a)
`ifdef VIP_FRAME_GEN_SCROLL_EN
    , .frame_cnt(fc_a)
`endif
  );

  vip_frame_stream_gen #(
    .IMG_H(4), .IMG_V(3), .H_BLANK(2), .VS_LINES(1), .V_BLANK(1), .CLKEN_DIV(2)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .pattern_sel(pat_b),
    .per_frame_vsync(vs_b), .per_frame_href(hr_b), .per_frame_clken(ce_b),
    .per_img_Y(y_b), .frame_done(fd_b), .busy(busy_b)
`ifdef VIP_FRAME_GEN_SCROLL_EN
    , .frame_cnt(fc_b)
`endif
  );

  vip_frame_stream_gen #(
    .IMG_H(16), .IMG_V(3), .H_BLANK(2), .VS_LINES(1), .V_BLANK(1), .CLKEN_DIV(1)
  ) dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .pattern_sel(pat_c),
    .per_frame_vsync(vs_c), .per_frame_href(hr_c), .per_frame_clken(ce_c),
    .per_img_Y(y_c), .frame_done(fd_c), .busy(busy_c)
`ifdef VIP_FRAME_GEN_SCROLL_EN
    , .frame_cnt(fc_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  int cap_vs[0:127];
  int cap_hr[0:127];
  int cap_ce[0:127];
  int cap_y[0:127];
  int cap_fd[0:127];
  int cap_busy[0:127];

  int s_vs, s_hr, s_ce, s_fd, s_fd_pos, s_hr_win, s_busy;
  int ys[$];

  // One line of dut_b's first active line (v=2, frame index 20..29)
  int exp_b_hr[0:9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_b_ce[0:9] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  int exp_b_y[0:9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int id, input int idx);
    case (id)
      0: begin
        cap_vs[idx] = int'(vs_a); cap_hr[idx] = int'(hr_a); cap_ce[idx] = int'(ce_a);
        cap_y[idx] = int'(y_a); cap_fd[idx] = int'(fd_a); cap_busy[idx] = int'(busy_a);
      end
      1: begin
        cap_vs[idx] = int'(vs_b); cap_hr[idx] = int'(hr_b); cap_ce[idx] = int'(ce_b);
        cap_y[idx] = int'(y_b); cap_fd[idx] = int'(fd_b); cap_busy[idx] = int'(busy_b);
      end
      default: begin
        cap_vs[idx] = int'(vs_c); cap_hr[idx] = int'(hr_c); cap_ce[idx] = int'(ce_c);
        cap_y[idx] = int'(y_c); cap_fd[idx] = int'(fd_c); cap_busy[idx] = int'(busy_c);
      end
    endcase
  endtask

  task automatic capture(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sample(id, i);
    end
  endtask

  task automatic summarize(input int n);
    int prev_hr;
    s_vs = 0; s_hr = 0; s_ce = 0; s_fd = 0; s_fd_pos = -1; s_hr_win = 0; s_busy = 0;
    prev_hr = 0;
    ys.delete();
    for (int i = 0; i < n; i++) begin
      s_vs   += cap_vs[i];
      s_hr   += cap_hr[i];
      s_ce   += cap_ce[i];
      s_busy += cap_busy[i];
      if (cap_fd[i] != 0) begin
        s_fd++;
        s_fd_pos = i;
      end
      if (cap_hr[i] != 0 && prev_hr == 0) s_hr_win++;
      prev_hr = cap_hr[i];
      if (cap_ce[i] != 0) ys.push_back(cap_y[i]);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_vsync"}, cap_vs[0], 0);
    check({tag, "_href"},  cap_hr[0], 0);
    check({tag, "_clken"}, cap_ce[0], 0);
    check({tag, "_y"},     cap_y[0], 0);
    check({tag, "_fd"},    cap_fd[0], 0);
    check({tag, "_busy"},  cap_busy[0], 0);
  endtask

  initial begin
    int n_ff;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    pat_a = PAT_HRAMP; pat_b = PAT_HRAMP; pat_c = PAT_HRAMP;

    // Reset state
    repeat (3) tick();
    sample(0, 0);
    check_all_low("rst");
`ifdef VIP_FRAME_GEN_SCROLL_EN
    check("rst_frame_cnt", int'(fc_a), 0);
`endif
    rst = 1'b0;
    tick();
    sample(0, 0);
    check_all_low("idle");

    // Frame 1 with enable held, h-ramp
    en_a = 1'b1;
    tick();
    sample(0, 0);
    check("start_lag_vsync", cap_vs[0], 0);
    check("start_lag_busy", cap_busy[0], 0);
    capture(0, 31);
    summarize(30);
    check("f1_vsync_cnt", s_vs, 6);
    check("f1_vsync_first", cap_vs[0], 1);
    check("f1_vsync_last", cap_vs[5], 1);
    check("f1_vsync_after", cap_vs[6], 0);
    check("f1_href_cnt", s_hr, 12);
    check("f1_href_win", s_hr_win, 3);
    check("f1_href_start", cap_hr[12], 1);
    check("f1_href_pre", cap_hr[11], 0);
    check("f1_href_end", cap_hr[16], 0);
    check("f1_clken_cnt", s_ce, 12);
    check("f1_fd_cnt", s_fd, 1);
    check("f1_fd_pos", s_fd_pos, 29);
    check("f1_busy_cnt", s_busy, 30);
    check("f1_next_vsync", cap_vs[30], 1);
    check("f1_next_busy", cap_busy[30], 1);
    check("f1_ys_n", ys.size(), 12);
    for (int k = 0; k < ys.size() && k < 12; k++) check("f1_y_hramp", ys[k], k % 4);

    // Frame 2: pattern changed mid-frame, old pattern must persist
    pat_a = PAT_VRAMP;
    capture(0, 29);
    summarize(29);
    check("f2_fd_pos", s_fd_pos, 28);
    check("f2_ys_n", ys.size(), 12);
    for (int k = 0; k < ys.size() && k < 12; k++)
      check("f2_y_keep_hramp", ys[k], (k % 4 + SCROLL * 1) % 256);

    // Frame 3: new pattern (v-ramp) takes effect
    capture(0, 30);
    summarize(30);
    check("f3_fd_pos", s_fd_pos, 29);
    check("f3_ys_n", ys.size(), 12);
    for (int k = 0; k < ys.size() && k < 12; k++)
      check("f3_y_vramp", ys[k], (k / 4 + SCROLL * 2) % 256);

    // Frame 4: flat pattern, enable dropped at cycle 10
    pat_a = PAT_FLAT;
    capture(0, 10);
    check("f4_start_vsync", cap_vs[0], 1);
    en_a = 1'b0;
    capture(0, 21);
    summarize(21);
    check("f4_clken_cnt", s_ce, 12);
    for (int k = 0; k < ys.size() && k < 12; k++) check("f4_y_flat", ys[k], 128);
    check("f4_fd_pos", s_fd_pos, 19);
    check("f4_busy_at_fd", cap_busy[19], 1);
    check("f4_stop_busy", cap_busy[20], 0);
    check("f4_stop_vsync", cap_vs[20], 0);
    check("f4_stop_href", cap_hr[20], 0);
    check("f4_stop_y", cap_y[20], 0);
    check("f4_stop_fd", cap_fd[20], 0);
    repeat (2) tick();
    sample(0, 0);
    check_all_low("f4_idle");

    // Checker on a 16-pixel line (dut_c), single frame
    en_c = 1'b1;
    pat_c = PAT_CHECK;
    tick();
    en_c = 1'b0;
    capture(2, 91);
    summarize(90);
    check("chk_clken_cnt", s_ce, 48);
    check("chk_fd_pos", s_fd_pos, 89);
    check("chk_ys_n", ys.size(), 48);
    for (int k = 0; k < ys.size() && k < 16; k++)
      check("chk_line0_y", ys[k], (k < 8) ? 0 : 255);
    n_ff = 0;
    for (int k = 0; k < ys.size(); k++) if (ys[k] == 255) n_ff++;
    check("chk_ff_cnt", n_ff, 24);
    check("chk_stop_busy", cap_busy[90], 0);

    // CLKEN_DIV=2 (dut_b), single frame
    en_b = 1'b1;
    pat_b = PAT_HRAMP;
    tick();
    en_b = 1'b0;
    capture(1, 51);
    summarize(50);
    check("div2_href_cnt", s_hr, 24);
    check("div2_href_win", s_hr_win, 3);
    check("div2_clken_cnt", s_ce, 12);
    check("div2_fd_pos", s_fd_pos, 49);
    check("div2_y_pre", cap_y[19], 0);
    for (int i = 0; i < 10; i++) begin
      check("div2_line_href", cap_hr[20 + i], exp_b_hr[i]);
      check("div2_line_clken", cap_ce[20 + i], exp_b_ce[i]);
      check("div2_line_y", cap_y[20 + i], exp_b_y[i]);
    end
    for (int k = 0; k < ys.size() && k < 12; k++) check("div2_y_hramp", ys[k], k % 4);
    check("div2_stop_busy", cap_busy[50], 0);

    // Reset asserted inside href
    en_a = 1'b1;
    pat_a = PAT_HRAMP;
    tick();
    capture(0, 14);
    check("rmid_in_href", cap_hr[13], 1);
    rst = 1'b1;
    tick();
    sample(0, 0);
    check_all_low("rmid");
`ifdef VIP_FRAME_GEN_SCROLL_EN
    check("rmid_frame_cnt", int'(fc_a), 0);
`endif
    rst = 1'b0;
    tick();
    sample(0, 0);
    check("rrel_lag_vsync", cap_vs[0], 0);
    tick();
    sample(0, 0);
    check("rrel_vsync", cap_vs[0], 1);
    check("rrel_busy", cap_busy[0], 1);
    check("rrel_href", cap_hr[0], 0);

    // Remainder of the fresh frame 1, then frame 2 (scroll visible if built in)
    capture(0, 29);
    summarize(29);
    check("r1_fd_pos", s_fd_pos, 28);
    for (int k = 0; k < ys.size() && k < 12; k++) check("r1_y_hramp", ys[k], k % 4);
`ifdef VIP_FRAME_GEN_SCROLL_EN
    check("r2_frame_cnt", int'(fc_a), 1);
`endif
    en_a = 1'b0;
    capture(0, 31);
    summarize(30);
    check("r2_fd_pos", s_fd_pos, 29);
    check("r2_ys_n", ys.size(), 12);
    for (int k = 0; k < ys.size() && k < 12; k++)
      check("r2_y_hramp", ys[k], (k % 4 + SCROLL * 1) % 256);
    check("r2_stop_busy", cap_busy[30], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
